// File: rtl/iteration_sync_controller.sv
// Sequencing block between broadcast controller, PE array, rings and motion update unit.
// Optional watchdog: define ITER_SYNC_TIMEOUT_EN to enable timeout_err; otherwise it is tied 0.
module iteration_sync_controller #(
  parameter int NUM_CELLS         = 64,
  parameter int NUM_RINGS         = 1,
  parameter int PARTICLE_ID_WIDTH = 7,
  parameter int RD_LATENCY        = 2,
  parameter int DRAIN_CYCLES      = 64,
  parameter int ITER_CNT_WIDTH    = 16,
  parameter int TIMEOUT_CYCLES    = 1048576
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [ITER_CNT_WIDTH-1:0]    num_iterations,
  input  logic                         bc_phase,
  input  logic                         bc_pause_reading,
  input  logic                         bc_reading_particle_num,
  input  logic [PARTICLE_ID_WIDTH-1:0] bc_particle_id,
  input  logic [PARTICLE_ID_WIDTH-1:0] bc_ref_id,
  input  logic [NUM_CELLS-1:0]         ref_wb_issued,
  input  logic                         goto_next_ref,
  input  logic [NUM_RINGS-1:0]         ring_empty,
  input  logic                         force_wr_any,
  input  logic                         force_buf_empty,
  input  logic                         filter_buf_empty,
  input  logic                         all_reading_done,
  input  logic                         mu_done,
  output logic                         pe_phase,
  output logic                         pe_pause_reading,
  output logic                         pe_reading_particle_num,
  output logic [PARTICLE_ID_WIDTH-1:0] pe_particle_id,
  output logic [PARTICLE_ID_WIDTH-1:0] pe_ref_id,
  output logic                         all_ref_wb_issued,
  output logic                         interconnect_empty,
  output logic                         all_force_wr_issued,
  output logic                         iter_start,
  output logic                         motion_update_start,
  output logic [ITER_CNT_WIDTH-1:0]    iter_count,
  output logic                         busy,
  output logic                         done,
  output logic                         timeout_err
);

  localparam int DL_W    = 3 + 2 * PARTICLE_ID_WIDTH;
  localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 2);
  localparam logic [DRAIN_W-1:0] DRAIN_MAX = DRAIN_W'(DRAIN_CYCLES);

  typedef enum logic {
    TRK_CAPTURE,
    TRK_DRAIN
  } trk_state_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FORCE,
    S_WAIT_MU,
    S_DONE
  } state_e;

  // ---------------------------------------------------------------------------
  // Broadcast delay line
  // ---------------------------------------------------------------------------
  logic [DL_W-1:0] dl_q [RD_LATENCY];

  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: the stages are reset (not left as plain storage) so pe_* reads 0 after reset, never X.
      for (int i = 0; i < RD_LATENCY; i++) dl_q[i] <= '0;
    end else begin
      dl_q[0] <= {bc_phase, bc_pause_reading, bc_reading_particle_num, bc_particle_id, bc_ref_id};
      for (int i = 1; i < RD_LATENCY; i++) dl_q[i] <= dl_q[i-1];
    end
  end

  assign {pe_phase, pe_pause_reading, pe_reading_particle_num, pe_particle_id, pe_ref_id} =
    dl_q[RD_LATENCY-1];

  // ---------------------------------------------------------------------------
  // Reference-writeback tracker and ring drain
  // ---------------------------------------------------------------------------
  trk_state_e           trk_state_q;
  logic [NUM_CELLS-1:0] cap_q;
  logic [DRAIN_W-1:0]   drain_cnt_q;
  logic                 all_ref_q;
  logic                 ic_q;
  logic                 iter_start_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      trk_state_q <= TRK_CAPTURE;
      cap_q       <= '0;
      drain_cnt_q <= '0;
      all_ref_q   <= 1'b0;
      ic_q        <= 1'b0;
    end else if (iter_start_q) begin
      trk_state_q <= TRK_CAPTURE;
      cap_q       <= '0;
      drain_cnt_q <= '0;
      all_ref_q   <= 1'b0;
      ic_q        <= 1'b0;
    end else begin
      case (trk_state_q)
        TRK_CAPTURE: begin
          cap_q <= cap_q | ref_wb_issued;
          if (&cap_q) begin
            all_ref_q   <= 1'b1;
            drain_cnt_q <= '0;
            trk_state_q <= TRK_DRAIN;
          end
        end
        TRK_DRAIN: begin
          if (goto_next_ref) begin
            // A writeback pulse coincident with the advance belongs to the next reference.
            cap_q       <= ref_wb_issued;
            all_ref_q   <= 1'b0;
            ic_q        <= 1'b0;
            drain_cnt_q <= '0;
            trk_state_q <= TRK_CAPTURE;
          end else begin
            if (drain_cnt_q != DRAIN_MAX) drain_cnt_q <= drain_cnt_q + DRAIN_W'(1);
            ic_q <= ic_q | ((drain_cnt_q == DRAIN_MAX) & (&ring_empty));
          end
        end
        default: trk_state_q <= TRK_CAPTURE;
      endcase
    end
  end

  assign all_ref_wb_issued   = all_ref_q;
  assign interconnect_empty  = ic_q;
  assign all_force_wr_issued = !force_wr_any & force_buf_empty & filter_buf_empty &
                               all_ref_q & ic_q;

  // ---------------------------------------------------------------------------
  // Iteration loop FSM
  // ---------------------------------------------------------------------------
  state_e                    state_q;
  logic                      mu_start_q;
  logic [ITER_CNT_WIDTH-1:0] iter_count_q;
  logic [ITER_CNT_WIDTH-1:0] num_iter_q;
  logic                      busy_q;
  logic                      done_q;
  logic [ITER_CNT_WIDTH-1:0] iter_count_inc;
  logic                      run_last;

  assign iter_count_inc = iter_count_q + ITER_CNT_WIDTH'(1);
  assign run_last       = (num_iter_q != '0) && (iter_count_inc == num_iter_q);

`ifdef ITER_SYNC_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  logic [WD_W-1:0] wd_q;
  logic            timeout_q;
  logic            wd_expired;

  // The pulse cycle itself counts as the first watched cycle.
  assign wd_expired = busy_q && !iter_start_q && !mu_start_q && (wd_q == WD_LAST);
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      iter_start_q <= 1'b0;
      mu_start_q   <= 1'b0;
      iter_count_q <= '0;
      num_iter_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef ITER_SYNC_TIMEOUT_EN
      wd_q         <= '0;
      timeout_q    <= 1'b0;
`endif
    end else begin
      iter_start_q <= 1'b0;
      mu_start_q   <= 1'b0;
`ifdef ITER_SYNC_TIMEOUT_EN
      if (iter_start_q || mu_start_q) wd_q <= WD_W'(1);
      else if (busy_q)                wd_q <= wd_q + WD_W'(1);

      if (wd_expired) begin
        timeout_q <= 1'b1;
        state_q   <= S_DONE;
        busy_q    <= 1'b0;
        done_q    <= 1'b1;
      end else
`endif
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            iter_start_q <= 1'b1;
            iter_count_q <= '0;
            num_iter_q   <= num_iterations;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
            state_q      <= S_FORCE;
`ifdef ITER_SYNC_TIMEOUT_EN
            timeout_q    <= 1'b0;
`endif
          end
        end
        S_FORCE: begin
          if (all_reading_done && all_force_wr_issued) begin
            mu_start_q <= 1'b1;
            state_q    <= S_WAIT_MU;
          end
        end
        S_WAIT_MU: begin
          if (mu_done) begin
            iter_count_q <= iter_count_inc;
            if (run_last) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              iter_start_q <= 1'b1;
              state_q      <= S_FORCE;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign iter_start          = iter_start_q;
  assign motion_update_start = mu_start_q;
  assign iter_count          = iter_count_q;
  assign busy                = busy_q;
  assign done                = done_q;
`ifdef ITER_SYNC_TIMEOUT_EN
  assign timeout_err         = timeout_q;
`else
  assign timeout_err         = 1'b0;
`endif

endmodule

// File: tb/tb_iteration_sync_controller.sv
// Scoreboard bench for iteration_sync_controller: delay line, ref tracker, drain and iteration loop.
module tb_iteration_sync_controller;

  localparam int NC  = 4;
  localparam int NR  = 2;
  localparam int PW  = 7;
  localparam int RDL = 3;
  localparam int DRN = 4;
  localparam int ICW = 16;
  localparam int TMO = 100;
  localparam int DLW = 3 + 2 * PW;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [ICW-1:0] num_iterations;
  logic           bc_phase, bc_pause_reading, bc_reading_particle_num;
  logic [PW-1:0]  bc_particle_id, bc_ref_id;
  logic [NC-1:0]  ref_wb_issued;
  logic           goto_next_ref;
  logic [NR-1:0]  ring_empty;
  logic           force_wr_any, force_buf_empty, filter_buf_empty;
  logic           all_reading_done, mu_done;
  logic           pe_phase, pe_pause_reading, pe_reading_particle_num;
  logic [PW-1:0]  pe_particle_id, pe_ref_id;
  logic           all_ref_wb_issued, interconnect_empty, all_force_wr_issued;
  logic           iter_start, motion_update_start;
  logic [ICW-1:0] iter_count;
  logic           busy, done, timeout_err;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct packed {
    logic           is_mu;
    logic [ICW-1:0] cnt;
  } ev_t;

  ev_t sb_q [$];

  always #5 clk = ~clk;

  iteration_sync_controller #(
    .NUM_CELLS(NC), .NUM_RINGS(NR), .PARTICLE_ID_WIDTH(PW), .RD_LATENCY(RDL),
    .DRAIN_CYCLES(DRN), .ITER_CNT_WIDTH(ICW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .num_iterations(num_iterations),
    .bc_phase(bc_phase), .bc_pause_reading(bc_pause_reading),
    .bc_reading_particle_num(bc_reading_particle_num),
    .bc_particle_id(bc_particle_id), .bc_ref_id(bc_ref_id),
    .ref_wb_issued(ref_wb_issued), .goto_next_ref(goto_next_ref), .ring_empty(ring_empty),
    .force_wr_any(force_wr_any), .force_buf_empty(force_buf_empty),
    .filter_buf_empty(filter_buf_empty), .all_reading_done(all_reading_done), .mu_done(mu_done),
    .pe_phase(pe_phase), .pe_pause_reading(pe_pause_reading),
    .pe_reading_particle_num(pe_reading_particle_num),
    .pe_particle_id(pe_particle_id), .pe_ref_id(pe_ref_id),
    .all_ref_wb_issued(all_ref_wb_issued), .interconnect_empty(interconnect_empty),
    .all_force_wr_issued(all_force_wr_issued), .iter_start(iter_start),
    .motion_update_start(motion_update_start), .iter_count(iter_count),
    .busy(busy), .done(done), .timeout_err(timeout_err)
  );

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, got stuck, required completion");
    $fatal(1);
  end

  // Advance one cycle; outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start = 1'b0; num_iterations = '0;
    {bc_phase, bc_pause_reading, bc_reading_particle_num} = 3'b000;
    bc_particle_id = '0; bc_ref_id = '0;
    ref_wb_issued = '0; goto_next_ref = 1'b0; ring_empty = '1;
    force_wr_any = 1'b0; force_buf_empty = 1'b1; filter_buf_empty = 1'b1;
    all_reading_done = 1'b1; mu_done = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle_inputs();
    tick();
    tick();
    rst = 1'b1;
  endtask

  // Advance one cycle and score any iter_start / motion_update_start pulse against the queue.
  task automatic tick_mon();
    ev_t ev;
    tick();
    if (iter_start || motion_update_start) begin
      vectors++;
      if (sb_q.size() == 0) begin
        miscompares++;
        $display("FAIL pulse_order: got unexpected %s pulse cnt=%0d, required no pulse",
                 motion_update_start ? "motion_update_start" : "iter_start", iter_count);
      end else begin
        ev = sb_q.pop_front();
        if (ev.is_mu !== motion_update_start || ev.cnt !== iter_count) begin
          miscompares++;
          $display("FAIL pulse_order: got %s cnt=%0d, required %s cnt=%0d",
                   motion_update_start ? "mu_start" : "iter_start", iter_count,
                   ev.is_mu ? "mu_start" : "iter_start", ev.cnt);
        end
      end
    end
  endtask

  task automatic wait_for(input bit want_mu, input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if ((want_mu ? motion_update_start : iter_start) === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick_mon();
    end
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_%s: got no pulse in %0d cycles, required pulse",
               want_mu ? "mu_start" : "iter_start", budget);
    end
  endtask

  // Entered in the cycle showing iter_start; drives one full force phase and motion update.
  task automatic run_iteration(input bit last, input logic [ICW-1:0] cnt_after);
    tick_mon();
    ref_wb_issued = '1; start = 1'b1; mu_done = 1'b1;
    tick_mon();
    ref_wb_issued = '0; start = 1'b0; mu_done = 1'b0;
    wait_for(1'b1, 30);
    goto_next_ref = 1'b1;
    tick_mon();
    goto_next_ref = 1'b0;
    tick_mon();
    mu_done = 1'b1;
    tick_mon();
    mu_done = 1'b0;
    vectors++;
    if (last) begin
      if (done !== 1'b1 || busy !== 1'b0 || iter_count !== cnt_after) begin
        miscompares++;
        $display("FAIL run_end: got done=%0b busy=%0b cnt=%0d, required done=1 busy=0 cnt=%0d",
                 done, busy, iter_count, cnt_after);
      end
    end else begin
      if (iter_start !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
        miscompares++;
        $display("FAIL back_to_back: got iter_start=%0b busy=%0b done=%0b, required 1 1 0",
                 iter_start, busy, done);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle_inputs();
    start = 1'b1; ref_wb_issued = '1; mu_done = 1'b1; goto_next_ref = 1'b1;
    bc_particle_id = 7'h55; bc_ref_id = 7'h2a; bc_phase = 1'b1;
    tick();
    tick();
    vectors++;
    if ({pe_phase, pe_pause_reading, pe_reading_particle_num, pe_particle_id, pe_ref_id} !== '0) begin
      miscompares++;
      $display("FAIL reset_pe: got %h, required 0", {pe_phase, pe_particle_id, pe_ref_id});
    end
    vectors++;
    if ({all_ref_wb_issued, interconnect_empty, all_force_wr_issued, iter_start,
         motion_update_start, busy, done, timeout_err} !== 8'h00 || iter_count !== '0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got flags=%b cnt=%0d, required flags=0 cnt=0",
               {all_ref_wb_issued, interconnect_empty, all_force_wr_issued, iter_start,
                motion_update_start, busy, done, timeout_err}, iter_count);
    end
    idle_inputs();
    rst = 1'b1;
    tick();
    vectors++;
    if (busy !== 1'b0 || iter_start !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_idle: got busy=%0b iter_start=%0b done=%0b, required 0 0 0",
               busy, iter_start, done);
    end
  endtask

  task automatic test_delay_line();
    logic [DLW-1:0] exp_q [$];
    logic [DLW-1:0] vec;
    logic [DLW-1:0] got;
    logic [DLW-1:0] exp;
    do_reset();
    for (int i = 0; i < RDL; i++) exp_q.push_back('0);
    for (int c = 0; c < 24; c++) begin
      if (exp_q.size() == RDL) begin
        exp = exp_q.pop_front();
        got = {pe_phase, pe_pause_reading, pe_reading_particle_num, pe_particle_id, pe_ref_id};
        vectors++;
        if (got !== exp) begin
          miscompares++;
          $display("FAIL delay_line c%0d: got %h, required %h", c, got, exp);
        end
      end
      vec = DLW'($urandom);
      if (c < 3) vec[2*PW-1:PW] = PW'(5 + c);
      {bc_phase, bc_pause_reading, bc_reading_particle_num, bc_particle_id, bc_ref_id} = vec;
      exp_q.push_back(vec);
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_tracker_drain();
    do_reset();
    for (int c = 0; c < 15; c++) begin
      vectors++;
      if (all_ref_wb_issued !== (c >= 5) || interconnect_empty !== (c >= 10) ||
          all_force_wr_issued !== (c >= 10)) begin
        miscompares++;
        $display("FAIL tracker c%0d: got ref=%0b ic=%0b afw=%0b, required %0b %0b %0b", c,
                 all_ref_wb_issued, interconnect_empty, all_force_wr_issued,
                 c >= 5, c >= 10, c >= 10);
      end
      if (c == 12) begin
        force_wr_any = 1'b1;
        #1;
        vectors++;
        if (all_force_wr_issued !== 1'b0) begin
          miscompares++;
          $display("FAIL force_wr_gate: got %0b, required 0", all_force_wr_issued);
        end
        force_wr_any = 1'b0;
      end
      ref_wb_issued = (c < 4) ? NC'(1 << c) : '0;
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_goto_next_ref();
    do_reset();
    for (int c = 0; c < 14; c++) begin
      if (c == 8 || c == 9 || c == 12 || c == 13) begin
        vectors++;
        if (all_ref_wb_issued !== (c == 8 || c == 13) || interconnect_empty !== (c == 8)) begin
          miscompares++;
          $display("FAIL goto_next_ref c%0d: got ref=%0b ic=%0b, required %0b %0b", c,
                   all_ref_wb_issued, interconnect_empty, c == 8 || c == 13, c == 8);
        end
      end
      goto_next_ref = (c == 8 || c == 9);
      case (c)
        0:       ref_wb_issued = 4'b1111;
        8:       ref_wb_issued = 4'b0010;
        9:       ref_wb_issued = 4'b0001;
        10:      ref_wb_issued = 4'b0100;
        11:      ref_wb_issued = 4'b1000;
        default: ref_wb_issued = 4'b0000;
      endcase
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_ring_drain();
    do_reset();
    for (int c = 0; c < 14; c++) begin
      vectors++;
      if (interconnect_empty !== (c >= 11)) begin
        miscompares++;
        $display("FAIL ring_drain c%0d: got %0b, required %0b", c, interconnect_empty, c >= 11);
      end
      ring_empty    = (c == 10 || c == 11) ? 2'b11 : 2'b01;
      ref_wb_issued = (c == 0) ? 4'b1111 : 4'b0000;
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_two_iterations();
    do_reset();
    sb_q.delete();
    sb_q.push_back('{1'b0, 16'd0});
    sb_q.push_back('{1'b1, 16'd0});
    sb_q.push_back('{1'b0, 16'd1});
    sb_q.push_back('{1'b1, 16'd1});
    num_iterations = 16'd2;
    start = 1'b1;
    tick_mon();
    start = 1'b0;
    num_iterations = 16'd1;
    wait_for(1'b0, 5);
    run_iteration(1'b0, 16'd1);
    run_iteration(1'b1, 16'd2);
    vectors++;
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL two_iter_pulses: got %0d pulses missing, required 0", sb_q.size());
    end
    idle_inputs();
  endtask

  task automatic test_run_forever_and_reset();
    do_reset();
    sb_q.delete();
    for (int i = 0; i < 3; i++) begin
      sb_q.push_back('{1'b0, ICW'(i)});
      sb_q.push_back('{1'b1, ICW'(i)});
    end
    sb_q.push_back('{1'b0, 16'd3});
    sb_q.push_back('{1'b1, 16'd3});
    num_iterations = '0;
    start = 1'b1;
    tick_mon();
    start = 1'b0;
    wait_for(1'b0, 5);
    for (int i = 1; i <= 3; i++) run_iteration(1'b0, ICW'(i));
    tick_mon();
    ref_wb_issued = '1;
    tick_mon();
    ref_wb_issued = '0;
    wait_for(1'b1, 30);
    vectors++;
    if (done !== 1'b0 || busy !== 1'b1 || iter_count !== 16'd3) begin
      miscompares++;
      $display("FAIL run_forever: got done=%0b busy=%0b cnt=%0d, required 0 1 3",
               done, busy, iter_count);
    end
    mu_done = 1'b1;
    rst = 1'b0;
    tick_mon();
    rst = 1'b1;
    mu_done = 1'b0;
    vectors++;
    if (iter_start !== 1'b0 || busy !== 1'b0 || iter_count !== '0 || all_ref_wb_issued !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_run: got iter_start=%0b busy=%0b cnt=%0d ref=%0b, required 0 0 0 0",
               iter_start, busy, iter_count, all_ref_wb_issued);
    end
    vectors++;
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL forever_pulses: got %0d pulses missing, required 0", sb_q.size());
    end
    idle_inputs();
  endtask

`ifdef ITER_SYNC_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    sb_q.delete();
    sb_q.push_back('{1'b0, 16'd0});
    sb_q.push_back('{1'b1, 16'd0});
    num_iterations = 16'd1;
    start = 1'b1;
    tick_mon();
    start = 1'b0;
    wait_for(1'b0, 5);
    tick_mon();
    ref_wb_issued = '1;
    tick_mon();
    ref_wb_issued = '0;
    wait_for(1'b1, 30);
    for (int k = 1; k <= TMO; k++) begin
      tick_mon();
      if (k == TMO - 1 || k == TMO) begin
        vectors++;
        if (timeout_err !== (k == TMO) || done !== (k == TMO)) begin
          miscompares++;
          $display("FAIL timeout k%0d: got err=%0b done=%0b, required %0b %0b", k,
                   timeout_err, done, k == TMO, k == TMO);
        end
      end
    end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    vectors++;
    if (timeout_err !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_clear: got err=%0b done=%0b, required 0 0", timeout_err, done);
    end
    idle_inputs();
  endtask
`endif

  initial begin
    idle_inputs();
    rst = 1'b0;
    test_reset();
    test_delay_line();
    test_tracker_drain();
    test_goto_next_ref();
    test_ring_drain();
    test_two_iterations();
    test_run_forever_and_reset();
`ifdef ITER_SYNC_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/iteration_sync_controller.md
Name: iteration_sync_controller

Overview:
Sequencing block between the broadcast controller, PE array, ring interconnect and motion update unit in the RL core. It delays the broadcast signals to the PEs by a parametrised read latency and tracks per-PE reference-writeback completion. It also waits out ring drain across multiple rings and runs the force-phase / motion-update iteration loop for a programmed iteration count.

Parameters:
NUM_CELLS, 64, number of PEs/cells
NUM_RINGS, 1, number of independent force-writeback rings
PARTICLE_ID_WIDTH, 7, particle/ref id width
RD_LATENCY, 2, broadcast-to-PE delay in cycles (>=1)
DRAIN_CYCLES, 64, minimum cycles after last ref writeback before interconnect is considered drained
ITER_CNT_WIDTH, 16, iteration counter width
TIMEOUT_CYCLES, 1048576, watchdog limit (used only with ITER_SYNC_TIMEOUT_EN)

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-low (reset when 0)
start  input  1  start run (honoured in IDLE/DONE)
num_iterations  input  ITER_CNT_WIDTH  iterations to run; 0 = run forever
bc_phase, bc_pause_reading, bc_reading_particle_num  input  1 each  from broadcast controller
bc_particle_id, bc_ref_id  input  PARTICLE_ID_WIDTH each  from broadcast controller
ref_wb_issued  input  NUM_CELLS  per-PE ref-writeback-issued pulses
goto_next_ref  input  1  broadcast controller advancing reference particle
ring_empty  input  NUM_RINGS  per-ring no-packet-in-flight flag
force_wr_any  input  1  any force cache write enable this cycle
force_buf_empty  input  1  all force-cache input buffers empty
filter_buf_empty  input  1  all PE filter buffers empty
all_reading_done  input  1  all PEs finished reading
mu_done  input  1  motion update complete pulse
pe_phase, pe_pause_reading, pe_reading_particle_num  output  1 each  bc_* delayed RD_LATENCY
pe_particle_id, pe_ref_id  output  PARTICLE_ID_WIDTH each  delayed RD_LATENCY
all_ref_wb_issued  output  1  every PE issued its ref writeback
interconnect_empty  output  1  drain complete
all_force_wr_issued  output  1  force phase fully written back
iter_start  output  1  pulse, to broadcast controller
motion_update_start  output  1  pulse, to motion update unit
iter_count  output  ITER_CNT_WIDTH  completed iterations
busy  output  1  state is FORCE or WAIT_MU
done  output  1  level, state is DONE
timeout_err  output  1  sticky watchdog error

Behaviour:
- Reset (rst==0 at posedge): all outputs 0, all delay stages 0, FSM IDLE, tracker CAPTURE, capture vector 0, drain counter 0.
- Delay line: RD_LATENCY register stages per bc_* signal. No enable, not reset-gated beyond reset. Output equals input exactly RD_LATENCY cycles earlier.
- Tracker, state CAPTURE:
  - cap <= cap | ref_wb_issued.
  - When &cap is 1 (registered): all_ref_wb_issued <= 1, drain_cnt <= 0, go to DRAIN.
- Tracker, state DRAIN:
  - drain_cnt increments, saturating at DRAIN_CYCLES.
  - interconnect_empty = (drain_cnt==DRAIN_CYCLES) & (&ring_empty), registered.
  - Both flags hold until goto_next_ref. Never self-clear on counter.
- goto_next_ref in DRAIN: clear all_ref_wb_issued, interconnect_empty and drain_cnt; cap <= ref_wb_issued. A pulse arriving in the same cycle is kept, not lost. Return to CAPTURE.
- goto_next_ref in CAPTURE is ignored.
- iter_start clears the tracker (cap = 0, CAPTURE, flags 0) in the cycle it is asserted.
- all_force_wr_issued = !force_wr_any & force_buf_empty & filter_buf_empty & all_ref_wb_issued & interconnect_empty (combinational).
- FSM:
  - IDLE: on start -> iter_start=1 for 1 cycle, iter_count<=0, go to FORCE.
  - FORCE: all_reading_done & all_force_wr_issued -> motion_update_start=1 for exactly 1 cycle, go to WAIT_MU.
  - WAIT_MU: on mu_done, iter_count<=iter_count+1.
    - If num_iterations!=0 and iter_count+1==num_iterations -> DONE.
    - Else -> iter_start pulse and FORCE (back-to-back, no idle cycle).
  - DONE: done=1; start -> same as IDLE start.
  - start in FORCE/WAIT_MU is ignored. mu_done outside WAIT_MU is ignored.
- iter_count wraps modulo 2^ITER_CNT_WIDTH only in run-forever mode.
- num_iterations is sampled at start.
- Reset mid-run returns to IDLE immediately; no pulses are emitted in the reset cycle.

Optional Feature:
ITER_SYNC_TIMEOUT_EN:
- Defined: a watchdog counter runs while busy and clears on every iter_start / motion_update_start. On reaching TIMEOUT_CYCLES, timeout_err is set (sticky until reset or start) and the FSM goes to DONE.
- Not defined: no counter logic; timeout_err tied 0.

Test Plan:
- RD_LATENCY=3; bc_particle_id 5,6,7 on cycles 0-2 -> pe_particle_id 5,6,7 on cycles 3-5.
- NUM_CELLS=4, DRAIN_CYCLES=4, ring_empty=1: ref_wb_issued bits pulse on cycles 0,1,2,3 ->
  - all_ref_wb_issued=1 at cycle 5;
  - interconnect_empty=1 at cycle 10;
  - both hold until goto_next_ref.
- goto_next_ref coincident with ref_wb_issued=4'b0010 -> flags clear next cycle, cap=4'b0010, later all-set requires only the other 3 bits.
- ring_empty=0 held past DRAIN_CYCLES -> interconnect_empty stays 0; it rises the cycle after ring_empty goes 1.
- num_iterations=2, full handshakes with all_reading_done=1 -> pulse order: iter_start, motion_update_start, mu_done, iter_start, motion_update_start, mu_done; then done=1, iter_count=2, busy=0.
- With ITER_SYNC_TIMEOUT_EN, TIMEOUT_CYCLES=100, mu_done withheld -> timeout_err=1 at 100 cycles after motion_update_start, done=1; rst=0 clears it.
